// File: rtl/pixel_pair_aligner.sv
// Two-stream pixel aligner: one FIFO per input stream, a lock-step pair
// output, a per-frame operation latch and raster position tracking.

// Single-clock FIFO with a registered ready. Ready is computed from the
// next-cycle count, so a pop while full cannot reopen ready that same cycle.
module pixel_pair_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  ready_o,
  output logic                  not_empty_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ready_q, ready_d;
  logic                  do_push, do_pop;

  // Clear drops anything presented in the same cycle.
  assign do_push = push_i && ready_q && !clear_i;
  assign do_pop  = pop_i && (cnt_q != '0) && !clear_i;

  // Next-state pointers, occupancy and ready.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      cnt_d = cnt_q + CW'(1);
      else if (!do_push && do_pop) cnt_d = cnt_q - CW'(1);
    end
    ready_d = (cnt_d < FULL_C);
  end

  // Control state register; ready is 0 while in reset.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
    end
  end

  // Storage write port.
  // NOTE: the data array has no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o     = mem_q[rd_ptr_q];
  assign ready_o     = ready_q;
  assign not_empty_o = (cnt_q != '0);
endmodule

module pixel_pair_aligner #(
  parameter int DATA_WIDTH      = 8,
  parameter int OPERATION_WIDTH = 2,
  parameter int FIFO_DEPTH      = 16,
  parameter int IMG_WIDTH       = 640,
  parameter int IMG_HEIGHT      = 480,
  localparam int COL_W = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1,
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic                       sync_clear,
  input  logic [OPERATION_WIDTH-1:0] op_cfg,
  input  logic                       a_valid,
  input  logic [DATA_WIDTH-1:0]      a_data,
  output logic                       a_ready,
  input  logic                       b_valid,
  input  logic [DATA_WIDTH-1:0]      b_data,
  output logic                       b_ready,
  output logic                       pixel_valid,
  output logic [DATA_WIDTH-1:0]      pixel_a,
  output logic [DATA_WIDTH-1:0]      pixel_b,
  output logic [OPERATION_WIDTH-1:0] operation,
  output logic                       frame_done,
  output logic [COL_W-1:0]           col_cnt,
  output logic [ROW_W-1:0]           row_cnt
);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  logic [DATA_WIDTH-1:0] a_head, b_head;
  logic                  a_not_empty, b_not_empty;
  logic                  pop;

  // Raster position of the next pair to be popped.
  logic [COL_W-1:0] nxt_col_q, nxt_col_d;
  logic [ROW_W-1:0] nxt_row_q, nxt_row_d;
  // Registered outputs.
  logic [COL_W-1:0]           col_q, col_d;
  logic [ROW_W-1:0]           row_q, row_d;
  logic [DATA_WIDTH-1:0]      pix_a_q, pix_a_d, pix_b_q, pix_b_d;
  logic [OPERATION_WIDTH-1:0] op_q, op_d;
  logic                       valid_q, valid_d;
  logic                       done_q, done_d;

  assign pop = enable && a_not_empty && b_not_empty && !sync_clear;

  pixel_pair_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (sync_clear),
    .push_i     (a_valid),
    .pop_i      (pop),
    .wdata_i    (a_data),
    .rdata_o    (a_head),
    .ready_o    (a_ready),
    .not_empty_o(a_not_empty)
  );

  pixel_pair_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (sync_clear),
    .push_i     (b_valid),
    .pop_i      (pop),
    .wdata_i    (b_data),
    .rdata_o    (b_head),
    .ready_o    (b_ready),
    .not_empty_o(b_not_empty)
  );

  // Pair emission, operation latch at frame start and raster advance.
  always_comb begin
    nxt_col_d = nxt_col_q;
    nxt_row_d = nxt_row_q;
    col_d     = col_q;
    row_d     = row_q;
    pix_a_d   = pix_a_q;
    pix_b_d   = pix_b_q;
    op_d      = op_q;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    if (sync_clear) begin
      nxt_col_d = '0;
      nxt_row_d = '0;
      col_d     = '0;
      row_d     = '0;
      op_d      = '0;
    end else if (pop) begin
      pix_a_d = a_head;
      pix_b_d = b_head;
      valid_d = 1'b1;
      col_d   = nxt_col_q;
      row_d   = nxt_row_q;
      done_d  = (nxt_col_q == COL_LAST) && (nxt_row_q == ROW_LAST);
      if (nxt_col_q == '0 && nxt_row_q == '0) op_d = op_cfg;
      if (nxt_col_q == COL_LAST) begin
        nxt_col_d = '0;
        nxt_row_d = (nxt_row_q == ROW_LAST) ? '0 : nxt_row_q + ROW_W'(1);
      end else begin
        nxt_col_d = nxt_col_q + COL_W'(1);
      end
    end
  end

  // Output and position registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nxt_col_q <= '0;
      nxt_row_q <= '0;
      col_q     <= '0;
      row_q     <= '0;
      pix_a_q   <= '0;
      pix_b_q   <= '0;
      op_q      <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      nxt_col_q <= nxt_col_d;
      nxt_row_q <= nxt_row_d;
      col_q     <= col_d;
      row_q     <= row_d;
      pix_a_q   <= pix_a_d;
      pix_b_q   <= pix_b_d;
      op_q      <= op_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

  assign pixel_valid = valid_q;
  assign pixel_a     = pix_a_q;
  assign pixel_b     = pix_b_q;
  assign operation   = op_q;
  assign frame_done  = done_q;
  assign col_cnt     = col_q;
  assign row_cnt     = row_q;
endmodule

// File: tb/tb_pixel_pair_aligner.sv
// Scoreboard bench for pixel_pair_aligner on a 4x2 frame with 16-deep FIFOs.
module tb_pixel_pair_aligner;
  localparam int DW = 8;
  localparam int OW = 2;
  localparam int DEPTH = 16;
  localparam int W = 4;
  localparam int H = 2;

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic          sync_clear;
  logic [OW-1:0] op_cfg;
  logic          a_valid;
  logic [DW-1:0] a_data;
  logic          a_ready;
  logic          b_valid;
  logic [DW-1:0] b_data;
  logic          b_ready;
  logic          pixel_valid;
  logic [DW-1:0] pixel_a;
  logic [DW-1:0] pixel_b;
  logic [OW-1:0] operation;
  logic          frame_done;
  logic [1:0]    col_cnt;
  logic [0:0]    row_cnt;

  pixel_pair_aligner #(
    .DATA_WIDTH(DW), .OPERATION_WIDTH(OW), .FIFO_DEPTH(DEPTH),
    .IMG_WIDTH(W), .IMG_HEIGHT(H)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .sync_clear (sync_clear),
    .op_cfg     (op_cfg),
    .a_valid    (a_valid),
    .a_data     (a_data),
    .a_ready    (a_ready),
    .b_valid    (b_valid),
    .b_data     (b_data),
    .b_ready    (b_ready),
    .pixel_valid(pixel_valid),
    .pixel_a    (pixel_a),
    .pixel_b    (pixel_b),
    .operation  (operation),
    .frame_done (frame_done),
    .col_cnt    (col_cnt),
    .row_cnt    (row_cnt)
  );

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [OW-1:0] op;
    int            col;
    int            row;
    logic          done;
    int            cyc;   // expected cycle of the pulse, -1 = don't care
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   n_valid = 0;
  int   exp_idx = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every pulse on pixel_valid must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && pixel_valid) begin
        n_valid++;
        if (sb_q.size() == 0) begin
          check("unexpected_pixel_valid", int'(pixel_valid), 0);
        end else begin
          e = sb_q.pop_front();
          check("pixel_a", int'(pixel_a), int'(e.a));
          check("pixel_b", int'(pixel_b), int'(e.b));
          check("operation", int'(operation), int'(e.op));
          check("col_cnt", int'(col_cnt), e.col);
          check("row_cnt", int'(row_cnt), e.row);
          check("frame_done", int'(frame_done), int'(e.done));
          if (e.cyc >= 0) check("pair_latency_cycle", cyc, e.cyc);
        end
      end
    end
  end

  // Queue the next expected pair; raster position follows from the pair index.
  task automatic expect_pair(input logic [DW-1:0] a, input logic [DW-1:0] b,
                             input logic [OW-1:0] op, input int exp_cyc);
    exp_t e;
    e.a    = a;
    e.b    = b;
    e.op   = op;
    e.col  = exp_idx % W;
    e.row  = (exp_idx / W) % H;
    e.done = ((exp_idx % (W * H)) == (W * H - 1));
    e.cyc  = exp_cyc;
    sb_q.push_back(e);
    exp_idx++;
  endtask

  // Present data on the selected streams until each is accepted.
  // Called and returns one time unit after a rising edge.
  task automatic drive(input bit use_a, input bit use_b,
                       input logic [DW-1:0] da, input logic [DW-1:0] db,
                       output int acc_cyc);
    bit got_a, got_b, ra, rb;
    int n;
    got_a = !use_a;
    got_b = !use_b;
    a_valid = use_a;
    a_data  = da;
    b_valid = use_b;
    b_data  = db;
    acc_cyc = -1;
    n = 0;
    while (!(got_a && got_b) && n < 200) begin
      @(negedge clk);
      ra = a_ready;
      rb = b_ready;
      @(posedge clk);
      #1;
      if (a_valid && ra) begin got_a = 1'b1; a_valid = 1'b0; acc_cyc = cyc; end
      if (b_valid && rb) begin got_b = 1'b1; b_valid = 1'b0; acc_cyc = cyc; end
      n++;
    end
    if (!(got_a && got_b)) check("push_accepted", int'(got_a && got_b), 1);
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (sb_q.size() != 0 && n < 500);
    #1;
    check("scoreboard_drained", sb_q.size(), 0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_cleared_outputs(input string tag);
    check({tag, "_pixel_valid"}, int'(pixel_valid), 0);
    check({tag, "_operation"}, int'(operation), 0);
    check({tag, "_frame_done"}, int'(frame_done), 0);
    check({tag, "_col_cnt"}, int'(col_cnt), 0);
    check({tag, "_row_cnt"}, int'(row_cnt), 0);
  endtask

  initial begin
    int acc;
    int base;
    rst_n = 1'b1;
    enable = 1'b0;
    sync_clear = 1'b0;
    op_cfg = '0;
    a_valid = 1'b0;
    a_data = '0;
    b_valid = 1'b0;
    b_data = '0;

    // Reset values, ready held low until the first edge after release.
    #2 rst_n = 1'b0;
    #1;
    check_cleared_outputs("reset");
    check("reset_pixel_a", int'(pixel_a), 0);
    check("reset_a_ready", int'(a_ready), 0);
    check("reset_b_ready", int'(b_ready), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("a_ready_before_first_edge", int'(a_ready), 0);
    idle(1);
    check("a_ready_after_release", int'(a_ready), 1);
    check("b_ready_after_release", int'(b_ready), 1);

    // Lockstep streams: first pulse one edge after the handshake edge.
    enable = 1'b1;
    op_cfg = 2'b01;
    drive(1, 1, 8'd10, 8'd1, acc);
    expect_pair(8'd10, 8'd1, 2'b01, acc + 1);
    drive(1, 1, 8'd20, 8'd2, acc);
    expect_pair(8'd20, 8'd2, 2'b01, -1);
    drive(1, 1, 8'd30, 8'd3, acc);
    expect_pair(8'd30, 8'd3, 2'b01, -1);
    wait_drain();

    // Skew: A runs 16 ahead and fills; ready reopens the cycle after the first pop.
    for (int i = 0; i < DEPTH; i++) drive(1, 0, DW'(i), 8'd0, acc);
    check("a_ready_when_full", int'(a_ready), 0);
    idle(2);
    check("a_ready_stays_full", int'(a_ready), 0);
    drive(0, 1, 8'd0, 8'd100, acc);
    for (int i = 0; i < DEPTH; i++) expect_pair(DW'(i), DW'(100 + i), 2'b01, -1);
    check("a_ready_during_pop", int'(a_ready), 0);
    idle(1);
    check("a_ready_after_pop", int'(a_ready), 1);
    for (int i = 1; i < DEPTH; i++) drive(0, 1, 8'd0, DW'(100 + i), acc);
    wait_drain();

    // Operation latch and frame end: op change at col 2 is ignored until the next frame.
    sync_clear = 1'b1;
    idle(1);
    sync_clear = 1'b0;
    exp_idx = 0;
    op_cfg = 2'b00;
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, DW'(40 + i), DW'(50 + i), acc);
      expect_pair(DW'(40 + i), DW'(50 + i), 2'b00, -1);
    end
    wait_drain();
    op_cfg = 2'b11;
    for (int i = 2; i < 8; i++) begin
      drive(1, 1, DW'(40 + i), DW'(50 + i), acc);
      expect_pair(DW'(40 + i), DW'(50 + i), 2'b00, -1);
    end
    drive(1, 1, 8'd48, 8'd58, acc);
    expect_pair(8'd48, 8'd58, 2'b11, -1);
    wait_drain();

    // Hold with enable=0, then sync_clear flushes buffered pairs and the dropped input.
    enable = 1'b0;
    for (int i = 0; i < 3; i++) drive(1, 1, DW'(200 + i), DW'(210 + i), acc);
    base = n_valid;
    idle(5);
    check("no_pairs_while_disabled", n_valid - base, 0);
    sync_clear = 1'b1;
    a_valid = 1'b1;
    a_data = 8'd99;
    idle(1);
    sync_clear = 1'b0;
    a_valid = 1'b0;
    exp_idx = 0;
    check_cleared_outputs("clear");
    check("clear_a_ready", int'(a_ready), 1);
    check("clear_b_ready", int'(b_ready), 1);
    enable = 1'b1;
    base = n_valid;
    idle(5);
    check("no_pairs_after_clear", n_valid - base, 0);
    drive(0, 1, 8'd0, 8'd7, acc);
    idle(4);
    check("dropped_input_not_paired", n_valid - base, 0);
    op_cfg = 2'b10;
    drive(1, 0, 8'd55, 8'd0, acc);
    expect_pair(8'd55, 8'd7, 2'b10, -1);
    wait_drain();

    // Async reset mid-frame with pairs still buffered.
    for (int i = 1; i < 4; i++) begin
      drive(1, 1, DW'(60 + i), DW'(70 + i), acc);
      expect_pair(DW'(60 + i), DW'(70 + i), 2'b10, -1);
    end
    wait_drain();
    enable = 1'b0;
    for (int i = 0; i < 2; i++) drive(1, 1, DW'(150 + i), DW'(160 + i), acc);
    #3 rst_n = 1'b0;
    #1;
    check_cleared_outputs("async_reset");
    check("async_reset_pixel_a", int'(pixel_a), 0);
    check("async_reset_pixel_b", int'(pixel_b), 0);
    check("async_reset_a_ready", int'(a_ready), 0);
    check("async_reset_b_ready", int'(b_ready), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);
    check("ready_after_second_release", int'(a_ready && b_ready), 1);
    exp_idx = 0;
    enable = 1'b1;
    op_cfg = 2'b01;
    base = n_valid;
    idle(4);
    check("buffered_pairs_flushed_by_reset", n_valid - base, 0);
    drive(1, 1, 8'd88, 8'd99, acc);
    expect_pair(8'd88, 8'd99, 2'b01, -1);
    wait_drain();
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
